// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the I-cache and
// D-cache miss paths. One request is outstanding at a time. Each request
// walks IDLE -> ISSUE -> WAIT -> DONE, and then returns to IDLE.
// Optional build macro ARB_RR_EN: when it is defined, simultaneous requests
// are resolved round-robin with a 1-bit pointer. When it is undefined, D
// always beats I.
module mem_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req,
  input  logic [15:0] ic_addr,
  output logic        ic_done,
  output logic [15:0] ic_data,
  input  logic        dc_req,
  input  logic        dc_wr,
  input  logic [15:0] dc_addr,
  input  logic [15:0] dc_wdata,
  output logic        dc_done,
  output logic [15:0] dc_data,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_stall,
  output logic        busy
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} stateT;

  stateT       state;
  stateT       nextState;
  logic        grantDc;   // 1 = D-cache owns the current operation
  logic        wrLat;
  logic [15:0] addrLat;
  logic [15:0] wdataLat;
  logic [3:0]  latCnt;
  logic        anyReq;
  logic        dcWins;

  assign anyReq = ic_req | dc_req;

`ifdef ARB_RR_EN
  logic rrPtr;            // 1 = D preferred, 0 = I preferred

  // The preferred port wins a tie; otherwise any lone requester wins
  always_comb begin
    dcWins = dc_req & (~ic_req | rrPtr);
  end

  // Hand preference to the other port whenever a grant is made
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rrPtr <= 1'b1;
    else if (state == IDLE && anyReq)
      rrPtr <= ~dcWins;
  end
`else
  // Fixed priority: D beats I whenever both are requesting
  always_comb begin
    dcWins = dc_req;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= nextState;
  end

  // Next-state decode
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = ISSUE;
      ISSUE:   if (!mem_stall) nextState = WAIT;
      WAIT:    if (latCnt == 4'd1) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Latch the winner's request in IDLE; clear the memory-side values on the way back to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grantDc  <= 1'b0;
      wrLat    <= 1'b0;
      addrLat  <= 16'd0;
      wdataLat <= 16'd0;
    end else if (state == IDLE && anyReq) begin
      grantDc  <= dcWins;
      wrLat    <= dcWins & dc_wr;
      addrLat  <= dcWins ? dc_addr : ic_addr;
      wdataLat <= dcWins ? dc_wdata : 16'd0;
    end else if (state == DONE) begin
      wrLat    <= 1'b0;
      addrLat  <= 16'd0;
      wdataLat <= 16'd0;
    end
  end

  // Load the latency counter on memory accept and count down while waiting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      latCnt <= 4'd0;
    else if (state == ISSUE && !mem_stall)
      latCnt <= LAT_INIT;
    else if (state == WAIT)
      latCnt <= latCnt - 4'd1;
  end

  // Capture read data for the granted port on the cycle mem_rdata is valid; writes leave both registers alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ic_data <= 16'd0;
      dc_data <= 16'd0;
    end else if (state == WAIT && latCnt == 4'd1 && !wrLat) begin
      if (grantDc)
        dc_data <= mem_rdata;
      else
        ic_data <= mem_rdata;
    end
  end

  // Moore-decoded outputs
  always_comb begin
    mem_rd    = (state == ISSUE) & ~wrLat;
    mem_wr    = (state == ISSUE) & wrLat;
    mem_addr  = addrLat;
    mem_wdata = wdataLat;
    busy      = (state != IDLE);
    ic_done   = (state == DONE) & ~grantDc;
    dc_done   = (state == DONE) & grantDc;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter. The stimulus pushes the expected completions
// (port and data). A negedge monitor pops an entry on every done pulse and compares it.
// The memory model returns data exactly MEM_LAT cycles after accept and drives junk in every other cycle.
module tb_mem_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ic_req = 1'b0;
  logic [15:0] ic_addr = 16'd0;
  logic        ic_done;
  logic [15:0] ic_data;
  logic        dc_req = 1'b0;
  logic        dc_wr = 1'b0;
  logic [15:0] dc_addr = 16'd0;
  logic [15:0] dc_wdata = 16'd0;
  logic        dc_done;
  logic [15:0] dc_data;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'hDEAD;
  logic        mem_stall = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        isDc;
    logic [15:0] data;
  } expT;
  expT expQ[$];

  mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_done(dc_done), .dc_data(dc_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory contents: one fixed word, and addr ^ 0x5A5A everywhere else
  function automatic logic [15:0] memVal(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // Memory model: a read is accepted at an edge where mem_rd=1 and mem_stall=0
  logic        accSeen = 1'b0;
  logic [15:0] accAddr = 16'd0;
  logic [15:0] rdAddr = 16'd0;
  int          cd = 0;

  always @(negedge clk) begin
    accSeen = mem_rd && !mem_stall;
    accAddr = mem_addr;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (accSeen) begin
        cd = MEM_LAT;
        rdAddr = accAddr;
        accSeen = 1'b0;
      end else if (cd > 0) begin
        cd--;
      end
      mem_rdata = (cd == 1) ? memVal(rdAddr) : 16'hDEAD;
    end
  end

  // Monitor: every done pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b1 && (ic_done || dc_done)) begin
      check("done with pending expectation", expQ.size() != 0, 1);
      if (expQ.size() != 0) begin
        expT e;
        e = expQ.pop_front();
        check("done port {ic,dc}", {ic_done, dc_done}, {!e.isDc, e.isDc});
        check("done data", dc_done ? dc_data : ic_data, e.data);
      end
    end
  end

  task automatic runOp(input string name, input logic isDc, input logic wr,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input int stallN, input bit dropEarly, input logic [15:0] expData);
    int lat;
    int strobes;
    bit seen;
    expT e;
    lat = -1;
    strobes = 0;
    seen = 1'b0;
    @(posedge clk);
    #1;
    if (isDc) begin
      dc_req = 1'b1; dc_wr = wr; dc_addr = addr; dc_wdata = wdata;
    end else begin
      ic_req = 1'b1; ic_addr = addr;
    end
    e.isDc = isDc;
    e.data = expData;
    expQ.push_back(e);
    for (int k = 0; k < 60 && !seen; k++) begin
      mem_stall = (k >= 1 && k <= stallN);
      if (k == 1) begin
        ic_addr = ~ic_addr; dc_addr = ~dc_addr; dc_wdata = ~dc_wdata;
      end
      if (k == 2 && dropEarly) begin
        ic_req = 1'b0; dc_req = 1'b0;
      end
      @(negedge clk);
      if (mem_rd || mem_wr) begin
        strobes++;
        check({name, " strobe {wr,rd}"}, {mem_wr, mem_rd}, {wr, !wr});
        check({name, " mem_addr"}, mem_addr, addr);
        if (wr) check({name, " mem_wdata"}, mem_wdata, wdata);
      end
      if (isDc ? dc_done : ic_done) begin
        seen = 1'b1;
        lat = k;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    mem_stall = 1'b0;
    check({name, " done latency"}, lat, MEM_LAT + 2 + stallN);
    check({name, " strobe cycles"}, strobes, stallN + 1);
    @(posedge clk);
    #1;
    ic_req = 1'b0;
    dc_req = 1'b0;
    dc_wr = 1'b0;
    @(negedge clk);
    check({name, " busy after done"}, busy, 0);
    check({name, " mem_addr cleared"}, mem_addr, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int icN;
    int dcN;
    bit icSaw;
    bit dcSaw;
    expT e;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset strobes/done/busy", {busy, mem_rd, mem_wr, ic_done, dc_done}, 5'b0);
    check("reset mem_addr", mem_addr, 16'h0000);
    check("reset mem_wdata", mem_wdata, 16'h0000);
    check("reset ic_data", ic_data, 16'h0000);
    check("reset dc_data", dc_data, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic reads and a write
    runOp("I-read", 1'b0, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, 16'hBEEF);
    runOp("D-read", 1'b1, 1'b0, 16'h0100, 16'h0000, 0, 1'b0, 16'h5B5A);
    runOp("D-write", 1'b1, 1'b1, 16'h0100, 16'h1234, 0, 1'b0, 16'h5B5A);
    check("ic_data held across D ops", ic_data, 16'hBEEF);
    check("dc_data unchanged by write", dc_data, 16'h5B5A);

    // Three stall cycles; the requester drops req mid-operation
    runOp("I-read stall", 1'b0, 1'b0, 16'h0040, 16'h0000, 3, 1'b1, 16'h5A1A);

    // Both ports request; each one re-requests once right after its first done
    @(posedge clk);
    #1;
    ic_req = 1'b1; ic_addr = 16'h0020;
    dc_req = 1'b1; dc_wr = 1'b0; dc_addr = 16'h0200;
`ifdef ARB_RR_EN
    e = '{1'b1, 16'h585A}; expQ.push_back(e);
    e = '{1'b0, 16'h5A7A}; expQ.push_back(e);
    e = '{1'b1, 16'h595A}; expQ.push_back(e);
    e = '{1'b0, 16'h5A6A}; expQ.push_back(e);
`else
    e = '{1'b1, 16'h585A}; expQ.push_back(e);
    e = '{1'b1, 16'h595A}; expQ.push_back(e);
    e = '{1'b0, 16'h5A7A}; expQ.push_back(e);
    e = '{1'b0, 16'h5A6A}; expQ.push_back(e);
`endif
    icN = 0;
    dcN = 0;
    for (int k = 0; k < 100 && (icN < 2 || dcN < 2); k++) begin
      @(negedge clk);
      icSaw = ic_done;
      dcSaw = dc_done;
      if (icSaw) icN++;
      if (dcSaw) dcN++;
      @(posedge clk);
      #1;
      if (icSaw) begin
        if (icN == 1) ic_addr = 16'h0030; else ic_req = 1'b0;
      end
      if (dcSaw) begin
        if (dcN == 1) dc_addr = 16'h0300; else dc_req = 1'b0;
      end
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    check("conflict completions {ic,dc}", {icN[7:0], dcN[7:0]}, {8'd2, 8'd2});
    @(negedge clk);
    check("conflict final ic_data", ic_data, 16'h5A6A);
    check("conflict final dc_data", dc_data, 16'h595A);

    // Asynchronous reset while in WAIT
    @(posedge clk);
    #1;
    dc_req = 1'b1; dc_wr = 1'b0; dc_addr = 16'h0400;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre-abort in WAIT {busy,rd,wr}", {busy, mem_rd, mem_wr}, 3'b100);
    #2;
    rst = 1'b0;
    #1;
    check("abort strobes/done/busy", {busy, mem_rd, mem_wr, ic_done, dc_done}, 5'b0);
    check("abort mem_addr", mem_addr, 16'h0000);
    check("abort ic_data", ic_data, 16'h0000);
    check("abort dc_data", dc_data, 16'h0000);
    dc_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post-abort idle {busy,ic_done,dc_done}", {busy, ic_done, dc_done}, 3'b000);
    end

    check("scoreboard drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter that shares the single main-memory port between the I-cache and D-cache miss paths.
- Sits between the fetch/memory-stage caches and the unified memory.
- Accepts one outstanding request at a time.
- Issues it to memory, waits the fixed memory latency, captures read data and returns a one-cycle done pulse to the granted requester.
- Applies stall back-pressure from memory.

Parameters:
- MEM_LAT, 2, cycles from memory accept to mem_rdata valid (legal range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ic_req  in  1  I-cache request, level, held until ic_done
- ic_addr  in  16  I-cache read address
- ic_done  out  1  one-cycle pulse, I-cache request complete
- ic_data  out  16  I-cache read data, valid with ic_done
- dc_req  in  1  D-cache request, level, held until dc_done
- dc_wr  in  1  1 = write, 0 = read
- dc_addr  in  16  D-cache address
- dc_wdata  in  16  D-cache write data
- dc_done  out  1  one-cycle pulse, D-cache request complete (read or write)
- dc_data  out  16  D-cache read data, valid with dc_done
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid exactly MEM_LAT cycles after accept
- mem_stall  in  1  memory not accepting this cycle
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; ic_data and dc_data registers 0; grant register 0; RR pointer = D.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered or Moore-decoded.
- IDLE:
  - Sample ic_req and dc_req.
  - If neither is high, stay in IDLE.
  - Otherwise latch the grant plus the winner's address, write flag and wdata, then go to ISSUE.
  - Default policy is fixed priority: D beats I when both are high.
- ISSUE:
  - mem_rd = !wr, mem_wr = wr.
  - mem_addr and mem_wdata come from the latched values.
  - If mem_stall = 1, stay in ISSUE with the strobe held.
  - If mem_stall = 0, memory accepts; load counter = MEM_LAT and go to WAIT.
- WAIT:
  - Strobes = 0; mem_addr and mem_wdata are held.
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, mem_rdata is valid. On that edge, load mem_rdata into the granted port's data register (reads only) and go to DONE.
- DONE:
  - Assert the granted port's done for exactly one cycle.
  - Always return to IDLE. This gives a one-cycle bubble, so a req still high during DONE is never re-granted.
- Latency, no stall: req high in IDLE at cycle t → ISSUE at t+1 → done at t+MEM_LAT+2. Each stall cycle adds 1.
- Requester drops req mid-operation: ignored; the operation completes and done still pulses.
- Requester changes addr or wdata after grant: ignored, because values are latched in IDLE.
- The non-granted data register holds its value; a write never modifies dc_data.
- mem_addr and mem_wdata return to 0 on entry to IDLE.
- Reset mid-operation: immediate abort to IDLE; no done is issued.

Optional Feature:
ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port.
  - On grant, the pointer moves to the other port.
  - On simultaneous requests, the pointer's port wins.
  - The pointer resets to D.
- Undefined: fixed D-over-I priority; no pointer register.

Test Plan:
- Reset then I-read: MEM_LAT=2, ic_req=1 with ic_addr=0x0010 in cycle 0; memory returns 0xBEEF → mem_rd=1 in cycle 1; ic_done=1 with ic_data=0xBEEF in cycle 4; busy=0 in cycle 5.
- D-write: dc_wr=1, dc_addr=0x0100, dc_wdata=0x1234 → mem_wr=1 with addr/wdata 0x0100/0x1234 for one cycle; dc_done at t+4; dc_data unchanged.
- Stall: mem_stall=1 for 3 cycles during ISSUE → mem_rd held for 4 cycles; done delayed by 3 cycles, arriving at t+7.
- Simultaneous requests, default build: ic_req and dc_req high together, both held → D served first, then I. With ARB_RR_EN, two back-to-back conflicts are served in order D, I, D, I.
- Async reset: assert rst low during WAIT → all outputs 0 immediately; no done pulse; state IDLE after release.
